// File: rtl/dsdaccel_window_sr.sv
// Sliding-window row buffer: assembles a staging row from byte or whole-row
// writes, commits it into a ROWS-deep chain and offers the window via valid/ready.
module dsdaccel_window_sr #(
    parameter int DW   = 8,
    parameter int COLS = 16,
    parameter int ROWS = 16,
    parameter int TAIL = 6
) (
    input  logic                              i_CLK,
    input  logic                              i_RST_n,
    input  logic                              i_CLR,
    output logic                              o_IN_READY,
    input  logic                              i_BYTE_VALID,
    input  logic [DW-1:0]                     i_BYTE_DIN,
    input  logic                              i_WORD_VALID,
    input  logic [COLS-1:0]                   i_WORD_MASK,
    input  logic [COLS*DW-1:0]                i_WORD_DIN,
    input  logic                              i_PAD_ROW,
    output logic [$clog2(COLS)-1:0]           o_COL_PTR,
    output logic [$clog2(ROWS+1)-1:0]         o_ROW_CNT,
    output logic                              o_WIN_VALID,
    input  logic                              i_WIN_READY,
    output logic [(ROWS*COLS+TAIL)*DW-1:0]    o_WIN
);

    localparam int CPW = $clog2(COLS);
    localparam int RCW = $clog2(ROWS+1);
    localparam logic [CPW-1:0] LAST_COL = CPW'(COLS-1);
    localparam logic [RCW-1:0] FULL_CNT = RCW'(ROWS);

    typedef logic [COLS-1:0][DW-1:0] row_t;
    typedef enum logic [1:0] {OP_NONE, OP_BYTE, OP_WORD, OP_PAD} op_e;

    row_t           stage_q, stage_d;
    row_t           chain_q [ROWS];
    logic [CPW-1:0] col_ptr_q, col_ptr_d;
    logic [RCW-1:0] row_cnt_q, row_cnt_d;
    logic           win_valid_q, win_valid_d;

    op_e            op;
    logic           commit;
    row_t           new_row;
    row_t           byte_row;
    row_t           word_row;

    // Stalled only while a window is on offer and the consumer is not taking it.
    assign o_IN_READY = !(win_valid_q && !i_WIN_READY);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        op         = OP_NONE;
        commit     = 1'b0;
        new_row    = '0;
        stage_d    = stage_q;
        col_ptr_d  = col_ptr_q;
        byte_row   = stage_q;
        word_row   = row_t'(i_WORD_DIN);

        byte_row[col_ptr_q] = i_BYTE_DIN;
        for (int c = 0; c < COLS; c++) begin
            if (i_WORD_MASK[c]) word_row[c] = '0;
        end

        if (o_IN_READY) begin
            if (i_PAD_ROW)         op = OP_PAD;
            else if (i_WORD_VALID) op = OP_WORD;
            else if (i_BYTE_VALID) op = OP_BYTE;
        end

        case (op)
            OP_BYTE: begin
                if (col_ptr_q == LAST_COL) begin
                    commit    = 1'b1;
                    new_row   = byte_row;
                    stage_d   = '0;
                    col_ptr_d = '0;
                end else begin
                    stage_d   = byte_row;
                    col_ptr_d = col_ptr_q + 1'b1;
                end
            end
            OP_WORD: begin
                commit    = 1'b1;
                new_row   = word_row;
                stage_d   = '0;
                col_ptr_d = '0;
            end
            OP_PAD: begin
                commit    = 1'b1;
                stage_d   = '0;
                col_ptr_d = '0;
            end
            default: ;
        endcase

        row_cnt_d = row_cnt_q;
        if (commit && row_cnt_q != FULL_CNT) row_cnt_d = row_cnt_q + 1'b1;

        // A commit on a full chain offers a fresh window even while one is being consumed.
        win_valid_d = win_valid_q;
        if (commit && row_cnt_d == FULL_CNT)  win_valid_d = 1'b1;
        else if (win_valid_q && i_WIN_READY)  win_valid_d = 1'b0;
    end

    always_ff @(posedge i_CLK) begin
        // NOTE: the chain is reset like any other register because the window must read zero after clear.
        if (!i_RST_n || i_CLR) begin
            stage_q     <= '0;
            col_ptr_q   <= '0;
            row_cnt_q   <= '0;
            win_valid_q <= 1'b0;
            for (int k = 0; k < ROWS; k++) chain_q[k] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so the shift reads pre-edge values.
            stage_q     <= stage_d;
            col_ptr_q   <= col_ptr_d;
            row_cnt_q   <= row_cnt_d;
            win_valid_q <= win_valid_d;
            if (commit) begin
                chain_q[0] <= new_row;
                for (int k = 1; k < ROWS; k++) chain_q[k] <= chain_q[k-1];
            end
        end
    end

    always_comb begin
        o_WIN = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                o_WIN[(r*COLS+c)*DW +: DW] = chain_q[ROWS-1-r][c];
            end
        end
        for (int t = 0; t < TAIL; t++) begin
            o_WIN[(ROWS*COLS+t)*DW +: DW] = stage_q[t];
        end
    end

    assign o_COL_PTR   = col_ptr_q;
    assign o_ROW_CNT   = row_cnt_q;
    assign o_WIN_VALID = win_valid_q;

endmodule

// File: tb/tb_dsdaccel_window_sr.sv
// Bench for dsdaccel_window_sr: directed scenarios plus random traffic,
// all compared against a queue-based model of the row chain.
module tb_dsdaccel_window_sr;

    localparam int DW   = 8;
    localparam int COLS = 16;
    localparam int ROWS = 16;
    localparam int TAIL = 6;
    localparam int WW   = (ROWS*COLS+TAIL)*DW;
    localparam int CPW  = $clog2(COLS);
    localparam int RCW  = $clog2(ROWS+1);

    logic                 clk = 1'b0;
    logic                 rst_n, clr;
    logic                 in_ready;
    logic                 byte_valid;
    logic [DW-1:0]        byte_din;
    logic                 word_valid;
    logic [COLS-1:0]      word_mask;
    logic [COLS*DW-1:0]   word_din;
    logic                 pad_row;
    logic [CPW-1:0]       col_ptr;
    logic [RCW-1:0]       row_cnt;
    logic                 win_valid;
    logic                 win_ready;
    logic [WW-1:0]        win;

    always #5 clk = ~clk;

    dsdaccel_window_sr #(.DW(DW), .COLS(COLS), .ROWS(ROWS), .TAIL(TAIL)) dut (
        .i_CLK(clk), .i_RST_n(rst_n), .i_CLR(clr), .o_IN_READY(in_ready),
        .i_BYTE_VALID(byte_valid), .i_BYTE_DIN(byte_din),
        .i_WORD_VALID(word_valid), .i_WORD_MASK(word_mask), .i_WORD_DIN(word_din),
        .i_PAD_ROW(pad_row), .o_COL_PTR(col_ptr), .o_ROW_CNT(row_cnt),
        .o_WIN_VALID(win_valid), .i_WIN_READY(win_ready), .o_WIN(win)
    );

    int checks = 0;
    int errors = 0;
    bit pre_ok = 1'b0;

    // Model: chain as a queue, newest row at index 0, always ROWS entries.
    logic [COLS*DW-1:0] m_chain[$];
    logic [DW-1:0]      m_stage[COLS];
    int                 m_ptr, m_cnt;
    bit                 m_valid;

    function automatic logic [WW-1:0] exp_win();
        logic [WW-1:0]      w;
        logic [COLS*DW-1:0] row;
        w = '0;
        for (int r = 0; r < ROWS; r++) begin
            row = m_chain[ROWS-1-r];
            for (int c = 0; c < COLS; c++) w[(r*COLS+c)*DW +: DW] = row[c*DW +: DW];
        end
        for (int t = 0; t < TAIL; t++) w[(ROWS*COLS+t)*DW +: DW] = m_stage[t];
        return w;
    endfunction

    function automatic logic [DW-1:0] elem(input logic [WW-1:0] w, input int e);
        return w[e*DW +: DW];
    endfunction

    task automatic model_reset();
        m_chain.delete();
        for (int i = 0; i < ROWS; i++) m_chain.push_back('0);
        for (int c = 0; c < COLS; c++) m_stage[c] = '0;
        m_ptr = 0; m_cnt = 0; m_valid = 1'b0;
    endtask

    task automatic model_commit(input logic [COLS*DW-1:0] row);
        m_chain.push_front(row);
        void'(m_chain.pop_back());
        if (m_cnt < ROWS) m_cnt++;
    endtask

    task automatic model_edge();
        bit                 was_valid, committed;
        logic [COLS*DW-1:0] row;
        was_valid = m_valid;
        committed = 1'b0;
        if (!rst_n || clr) begin
            model_reset();
            return;
        end
        if (m_valid && !win_ready) return;
        if (pad_row) begin
            model_commit('0);
            committed = 1'b1;
        end else if (word_valid) begin
            row = word_din;
            for (int c = 0; c < COLS; c++) if (word_mask[c]) row[c*DW +: DW] = '0;
            model_commit(row);
            committed = 1'b1;
        end else if (byte_valid) begin
            m_stage[m_ptr] = byte_din;
            m_ptr++;
            if (m_ptr == COLS) begin
                for (int c = 0; c < COLS; c++) row[c*DW +: DW] = m_stage[c];
                model_commit(row);
                committed = 1'b1;
            end
        end
        if (committed) begin
            for (int c = 0; c < COLS; c++) m_stage[c] = '0;
            m_ptr = 0;
        end
        if (committed && m_cnt == ROWS) m_valid = 1'b1;
        else if (was_valid && win_ready) m_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_win(input string tag, input logic [WW-1:0] exp);
        int idx;
        checks++;
        assert (win === exp) else begin
            errors++;
            idx = 0;
            for (int e = ROWS*COLS+TAIL-1; e >= 0; e--) if (elem(win, e) !== elem(exp, e)) idx = e;
            $error("FAIL %s window: element %0d observed %0h expected %0h", tag, idx, elem(win, idx), elem(exp, idx));
        end
    endtask

    // One clock: check combinational ready before the edge, state after it.
    task automatic tick(input string tag);
        #1;
        if (pre_ok) check({tag, " in_ready"}, 32'(in_ready), 32'(!(m_valid && !win_ready)));
        @(posedge clk);
        model_edge();
        pre_ok = 1'b1;
        #1;
        check_win(tag, exp_win());
        check({tag, " col_ptr"}, 32'(col_ptr), 32'(m_ptr));
        check({tag, " row_cnt"}, 32'(row_cnt), 32'(m_cnt));
        check({tag, " win_valid"}, 32'(win_valid), 32'(m_valid));
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; clr = 1'b0; pad_row = 1'b0; word_valid = 1'b0;
        byte_valid = 1'b0; word_mask = '0; word_din = '0; byte_din = '0;
    endtask

    task automatic do_byte(input logic [DW-1:0] b, input string tag);
        byte_valid = 1'b1; byte_din = b;
        tick(tag);
        byte_valid = 1'b0;
    endtask

    task automatic do_word(input logic [COLS*DW-1:0] d, input logic [COLS-1:0] m, input string tag);
        word_valid = 1'b1; word_din = d; word_mask = m;
        tick(tag);
        word_valid = 1'b0; word_mask = '0;
    endtask

    logic [WW-1:0]      saved_win;
    logic [COLS*DW-1:0] row;

    initial begin
        model_reset();

        // Reset with random inputs on every other pin.
        rst_n = 1'b0; clr = $urandom_range(0, 1); pad_row = $urandom_range(0, 1);
        word_valid = 1'b1; byte_valid = 1'b1; word_mask = COLS'($urandom);
        word_din = {$urandom, $urandom, $urandom, $urandom}; byte_din = DW'($urandom);
        win_ready = $urandom_range(0, 1);
        tick("reset");
        check_win("reset zero", '0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        idle_inputs();
        win_ready = 1'b0;

        // Fill by words.
        for (int n = 0; n < ROWS; n++) begin
            for (int c = 0; c < COLS; c++) row[c*DW +: DW] = DW'(n*16 + c);
            do_word(row, '0, "fill");
            if (n == ROWS-2) check("fill valid before last", 32'(win_valid), 32'd0);
        end
        check("fill valid", 32'(win_valid), 32'd1);
        check("fill elem0", 32'(elem(win, 0)), 32'h00);
        check("fill elem255", 32'(elem(win, 255)), 32'hFF);
        check("fill row_cnt", 32'(row_cnt), 32'd16);
        check("fill in_ready", 32'(in_ready), 32'd0);

        // Back-pressure: byte dropped, then one consume cycle.
        saved_win = win;
        do_byte(8'h55, "stall byte");
        check_win("stall unchanged", saved_win);
        check("stall col_ptr", 32'(col_ptr), 32'd0);
        win_ready = 1'b1;
        tick("consume");
        check("consume valid", 32'(win_valid), 32'd0);
        win_ready = 1'b0;

        // Byte stream.
        for (int i = 0; i < 5; i++) do_byte(DW'(8'hA1 + i), "bytes5");
        for (int i = 0; i < 5; i++) check("tail byte", 32'(elem(win, 256+i)), 32'(8'hA1 + i));
        check("tail elem261", 32'(elem(win, 261)), 32'h00);
        check("bytes5 col_ptr", 32'(col_ptr), 32'd5);
        for (int i = 0; i < 11; i++) do_byte(DW'(8'hB0 + i), "bytes11");
        check("byte commit col_ptr", 32'(col_ptr), 32'd0);
        check("byte commit tail", 32'(elem(win, 256)), 32'h00);
        check("byte commit valid", 32'(win_valid), 32'd1);
        check("byte commit newest c4", 32'(elem(win, 240+4)), 32'hA5);
        check("byte commit newest c15", 32'(elem(win, 255)), 32'hBA);

        // Mask, then PAD beats WORD and BYTE in the same cycle.
        win_ready = 1'b1;
        do_word({COLS{8'h77}}, 16'h8001, "mask");
        check("mask c0", 32'(elem(win, 240)), 32'h00);
        check("mask c15", 32'(elem(win, 255)), 32'h00);
        check("mask c1", 32'(elem(win, 241)), 32'h77);
        for (int i = 0; i < 3; i++) do_byte(DW'(8'hC0 + i), "partial");
        pad_row = 1'b1; word_valid = 1'b1; word_din = {COLS{8'h33}}; byte_valid = 1'b1; byte_din = 8'h99;
        tick("priority");
        idle_inputs();
        for (int c = 0; c < COLS; c++) check("pad row zero", 32'(elem(win, 240+c)), 32'h00);
        check("pad tail clear", 32'(elem(win, 256)), 32'h00);
        check("pad col_ptr", 32'(col_ptr), 32'd0);

        // Clear mid-row, with other requests present.
        for (int i = 0; i < 7; i++) do_byte(DW'(8'hD0 + i), "pre-clear");
        check("pre-clear col_ptr", 32'(col_ptr), 32'd7);
        clr = 1'b1; word_valid = 1'b1; word_din = {COLS{8'h44}};
        tick("clear");
        idle_inputs();
        check_win("clear zero", '0);
        check("clear col_ptr", 32'(col_ptr), 32'd0);
        check("clear row_cnt", 32'(row_cnt), 32'd0);
        check("clear valid", 32'(win_valid), 32'd0);
        win_ready = 1'b0;
        for (int n = 0; n < ROWS-1; n++) do_word({COLS{DW'(n+1)}}, '0, "refill");
        check("refill valid15", 32'(win_valid), 32'd0);
        check("refill cnt15", 32'(row_cnt), 32'd15);
        do_word({COLS{8'hEE}}, '0, "refill16");
        check("refill valid16", 32'(win_valid), 32'd1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            clr        = ($urandom_range(0, 199) == 0);
            pad_row    = ($urandom_range(0, 15) == 0);
            word_valid = ($urandom_range(0, 3) == 0);
            byte_valid = ($urandom_range(0, 1) == 0);
            word_mask  = ($urandom_range(0, 3) == 0) ? COLS'($urandom) : '0;
            word_din   = {$urandom, $urandom, $urandom, $urandom};
            byte_din   = DW'($urandom);
            win_ready  = ($urandom_range(0, 2) == 0);
            tick("random");
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
